// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
// Rounding of the averaged sample is enabled with SAR_SEQ_ROUND_EN.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_e;

  localparam int RESULT_W_DEF = 8;

  // One spare bit above the 2^al sum keeps the accumulator overflow-free.
  function automatic int acc_width(input int rw, input int al);
    return rw + al + 1;
  endfunction

endpackage

// File: rtl/sar_sequencer_if.sv
// Controller handshake (go/valid/result) and sample stream (valid/ready).
// master = sequencer, slave = controller plus downstream consumer.
interface sar_sequencer_if
  import sar_pkg::*;
#(
  parameter int W = RESULT_W_DEF
) ();

  logic         go;
  logic         valid;
  logic [W-1:0] result;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output go,
    input  valid,
    input  result,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  go,
    output valid,
    output result,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sar_seq_fifo.sv
// First-word-fall-through sample FIFO; a pop frees room for a push
// in the same cycle, so full+push+pop accepts both.
module sar_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         pop_ok;
  logic         push_ok;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) &&
              (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    wr_d    = wr_q + (AW+1)'(push_ok);
    rd_d    = rd_q + (AW+1)'(pop_ok);
    rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sar_sequencer.sv
// Runs SAR conversions back to back, averages 2^AVG_LOG2 results per sample.
// SAR_SEQ_ROUND_EN selects round-half-up with saturation instead of truncation.
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int RESULT_W    = RESULT_W_DEF,
  parameter int AVG_LOG2    = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clr_err,
  sar_sequencer_if.master bus,
  output logic            overflow,
  output logic            timeout_err
);

  localparam int ACC_W = acc_width(RESULT_W, AVG_LOG2);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << AVG_LOG2;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;
  logic                push;
  logic                tmo_set;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [RESULT_W-1:0] avg;

`ifdef SAR_SEQ_ROUND_EN
  localparam logic [ACC_W-1:0] HALF = (ACC_W'(1) << AVG_LOG2) >> 1;
  logic [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (acc_q + HALF) >> AVG_LOG2;
    avg = (|rnd[ACC_W-1:RESULT_W]) ? '1 : rnd[RESULT_W-1:0];
  end
`else
  assign avg = RESULT_W'(acc_q >> AVG_LOG2);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    push    = 1'b0;
    tmo_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (bus.valid) begin
          acc_d   = acc_q + ACC_W'(bus.result);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_GAP;
        end else if (tmr_q == TMR_LAST) begin
          tmo_set = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (!enable) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        tmr_d = '0;
        // a partial average never survives a stop
        if (cnt_q == CNT_FULL) begin
          push  = 1'b1;
          acc_d = '0;
          cnt_d = '0;
        end else if (!enable) begin
          acc_d = '0;
          cnt_d = '0;
        end
        state_d = enable ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drop  = push & fifo_full & ~bus.out_ready;
    ovf_d = (ovf_q & ~clr_err) | drop;
    tmo_d = (tmo_q & ~clr_err) | tmo_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  sar_seq_fifo #(
    .W     (RESULT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (avg),
    .pop       (bus.out_ready),
    .rd_data   (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.go        = (state_q == S_RUN);
  assign bus.out_valid = ~fifo_empty;
  assign overflow      = ovf_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: fixed-latency controller model, queue-based
// sample model compared every cycle, plus directed literal checks.
module tb_sar_sequencer;

  localparam int RW = 8;
  localparam int AL = 2;
  localparam int FD = 4;
  localparam int TO = 32;

`ifdef SAR_SEQ_ROUND_EN
  localparam logic [7:0] B_EXP = 8'h41;
`else
  localparam logic [7:0] B_EXP = 8'h40;
`endif

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic clr_err;
  logic overflow;
  logic timeout_err;

  sar_sequencer_if #(.W(RW)) bus ();

  sar_sequencer #(
    .RESULT_W    (RW),
    .AVG_LOG2    (AL),
    .FIFO_DEPTH  (FD),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clr_err     (clr_err),
    .bus         (bus),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] avg_of(input int s);
    int r;
`ifdef SAR_SEQ_ROUND_EN
    r = (s + ((1 << AL) / 2)) >> AL;
    if (r > 255) r = 255;
`else
    r = s >> AL;
`endif
    return 8'(r);
  endfunction

  // Controller: result presented so it is sampled on the 11th edge after go rises.
  logic [7:0] res_q[$];
  bit         hold_valid = 1'b0;
  int         conv_done = 0;
  int         k = 0;

  always @(negedge clk) begin
    if (!bus.go) begin
      k = 0;
      bus.valid = 1'b0;
    end else begin
      if (k == 10 && !hold_valid) begin
        bus.valid  = 1'b1;
        bus.result = (res_q.size() != 0) ? res_q.pop_front() : 8'h00;
        conv_done++;
      end else begin
        bus.valid = 1'b0;
      end
      k++;
    end
  end

  // Sample model: group results, push average after the gap, FIFO of FD.
  logic [7:0] mq[$];
  int         g_n;
  int         g_sum;
  bit         pend;
  logic [7:0] pend_v;
  bit         m_ov;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      g_n   = 0;
      g_sum = 0;
      pend  = 1'b0;
      m_ov  = 1'b0;
    end else begin : step
      bit drop;
      drop = 1'b0;
      if (bus.out_ready && mq.size() != 0) void'(mq.pop_front());
      if (pend) begin
        if (mq.size() < FD) mq.push_back(pend_v);
        else drop = 1'b1;
      end
      m_ov = (m_ov && !clr_err) || drop;
      pend = 1'b0;
      if (bus.valid) begin
        g_sum += int'(bus.result);
        g_n++;
        if (g_n == (1 << AL)) begin
          pend   = 1'b1;
          pend_v = avg_of(g_sum);
          g_n    = 0;
          g_sum  = 0;
        end
      end else if (!enable) begin
        g_n   = 0;
        g_sum = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", bus.out_valid, mq.size() != 0);
    check("out_data", bus.out_data, (mq.size() != 0) ? mq[0] : 8'h00);
    check("overflow", overflow, m_ov);
  end

  task automatic wait_conv(input int target, input int budget);
    int c;
    c = 0;
    while (conv_done < target) begin
      @(posedge clk);
      c++;
      if (c > budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_conv: got %0d conversions, required %0d",
                 conv_done, target);
        return;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lows;
    int hi;
    int base;

    rst = 1'b1;
    enable = 1'b0;
    clr_err = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", bus.go, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    rst = 1'b0;

    // A: 0x40,0x42,0x44,0x46 -> 0x43, 48 cycles after go rises
    res_q = '{8'h40, 8'h42, 8'h44, 8'h46};
    bus.out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("a_go_rise", bus.go, 1'b1);
    n = 0;
    lows = 0;
    while (!bus.out_valid && n < 200) begin
      if (!bus.go) lows++;
      @(negedge clk);
      n++;
    end
    check("a_latency", n, 48);
    check("a_go_low_cycles", lows, 4);
    check("a_sample", bus.out_data, 8'h43);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("a_idle_go", bus.go, 1'b0);

    // B: truncation/rounding, then saturation-range input
    bus.out_ready = 1'b0;
    res_q = '{8'h40, 8'h40, 8'h40, 8'h43, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    base = conv_done;
    enable = 1'b1;
    wait_conv(base + 8, 300);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("b_avg", bus.out_data, B_EXP);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b_sat", bus.out_data, 8'hFF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // C: stalled conversion
    hold_valid = 1'b1;
    enable = 1'b1;
    n = 0;
    while (!bus.go && n < 10) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (bus.go && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    enable = 1'b0;
    check("c_go_high", hi, TO);
    check("c_timeout_set", timeout_err, 1'b1);
    @(negedge clk);
    check("c_idle", bus.go, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("c_timeout_clr", timeout_err, 1'b0);
    hold_valid = 1'b0;

    // D: five samples into a four-entry FIFO, then push+pop when full
    for (int s = 0; s < 5; s++)
      for (int j = 0; j < 4; j++)
        res_q.push_back(8'(8'h11 * (s + 1)));
    base = conv_done;
    enable = 1'b1;
    wait_conv(base + 20, 600);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("d_overflow", overflow, 1'b1);
    check("d_head", bus.out_data, 8'h11);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("d_ovf_clr", overflow, 1'b0);
    res_q = '{8'h66, 8'h66, 8'h66, 8'h66};
    base = conv_done;
    enable = 1'b1;
    wait_conv(base + 4, 200);
    @(negedge clk);
    bus.out_ready = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("d_pushpop_ovf", overflow, 1'b0);
    check("d_pushpop_head", bus.out_data, 8'h22);
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.out_ready = 1'b0;
    check("d_drained", bus.out_valid, 1'b0);

    // E: stop after 2 of 4 conversions, then 4 fresh ones
    res_q = '{8'h10, 8'h10};
    base = conv_done;
    enable = 1'b1;
    wait_conv(base + 2, 100);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("e_no_push", bus.out_valid, 1'b0);
    res_q = '{8'h80, 8'h80, 8'h80, 8'h80};
    base = conv_done;
    enable = 1'b1;
    wait_conv(base + 4, 200);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("e_fresh", bus.out_data, 8'h80);

    // F: asynchronous reset in the middle of a conversion
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("f_go_pre", bus.go, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("f_go_async", bus.go, 1'b0);
    check("f_fifo_empty", bus.out_valid, 1'b0);
    check("f_overflow", overflow, 1'b0);
    check("f_timeout", timeout_err, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sar_sequencer.md
# sar_sequencer

- Drives the SAR controller's `go`/`valid`/`result` handshake from the consumer side.
- Repeatedly starts conversions and captures each finished `result`.
- Averages 2^AVG_LOG2 conversions into one sample and buffers samples in a small first-word-fall-through FIFO with a valid/ready output.
- Sits between the SAR controller and the downstream digital filter/readout logic.
- Detects stalled conversions (timeout) and FIFO overflow.

## Interface
- RESULT_W, 8, width of the controller `result` and of output samples
- AVG_LOG2, 2, log2 of conversions averaged per output sample (0 = no averaging)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- TIMEOUT_CYC, 32, maximum cycles `go` may stay high without `valid`
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = run conversions continuously
- clr_err  in  1  synchronous clear of sticky error flags
- go  out  1  to controller; high = perform conversion
- valid  in  1  from controller; conversion finished
- result  in  RESULT_W  from controller; sampled only when `valid`=1
- out_data  out  RESULT_W  FIFO head (averaged sample)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts head when `out_valid`&&`out_ready`
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- timeout_err  out  1  sticky; a conversion exceeded TIMEOUT_CYC

## Operation
- FSM states: IDLE, RUN, GAP.
  - `go` = (state == RUN), decoded from the state flops only.
- IDLE: when `enable`=1, go to RUN; clear the timer.
- RUN:
  - Timer increments each cycle.
  - `valid`=1: acc += result, cnt += 1, go to GAP.
  - Timer reaches TIMEOUT_CYC-1 without `valid`: set `timeout_err`, clear acc/cnt, go to IDLE.
  - `enable`=0: clear acc/cnt, go to IDLE, discarding the partial average.
- GAP: lasts exactly one cycle and holds `go` low so the controller returns to its wait state.
  - If cnt == 2^AVG_LOG2: push the average, clear acc/cnt.
  - Next state is RUN if `enable`=1, else IDLE.
- Accumulator width: RESULT_W+AVG_LOG2+1 bits, which cannot overflow.
- Average = acc >> AVG_LOG2, truncated. For rounding see Configuration.
- FIFO:
  - Push when full and no pop in the same cycle: sample dropped, `overflow` set.
  - Push and pop in the same cycle when full: both accepted.
  - Pop when empty: ignored.
- Sticky flags clear only on `rst` or `clr_err`=1. If `clr_err` and a new error event occur in the same cycle, the set wins.
- The FIFO contents are retained when `enable` drops.

## Timing
- Reset values:
  - state IDLE; `go`=0, `out_valid`=0, `out_data`=0, `overflow`=0, `timeout_err`=0.
  - acc=0, cnt=0, timer=0; FIFO empty.
- `go` rises one cycle after `enable` is sampled high in IDLE.
- With the 8-bit controller, `valid` is sampled high on the 11th rising edge after `go` rises.
  - One conversion period = 12 cycles (11 RUN + 1 GAP).
  - One output sample = 12·2^AVG_LOG2 cycles.
- A pushed sample appears on `out_data`/`out_valid` on the edge after the GAP cycle (FWFT, no extra latency).
- An asynchronous `rst` mid-conversion drops `go` immediately. The controller then resets itself through `go`=0.

## Configuration
- SAR_SEQ_ROUND_EN defined:
  - Average = (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2, round-half-up.
  - The result is saturated to 2^RESULT_W-1.
  - When AVG_LOG2=0, no rounding term is added.
- SAR_SEQ_ROUND_EN undefined: plain truncation, no saturation logic.

## Structure
- Shared package `sar_pkg`:
  - state enum (IDLE/RUN/GAP)
  - default RESULT_W
  - a helper constant for accumulator width
- One sub-module, `sar_seq_fifo`: parameterised FWFT FIFO with push/pop/full/empty.
  - The full-and-pop same-cycle rule is implemented inside it.
- FSM, accumulator, timer and error flags live in the top.

## Test plan
- Real controller plus comparator model giving results 0x40, 0x42, 0x44, 0x46, `out_ready`=1 -> one sample 0x43 appears 48 cycles after `go` first rises; `go` is low exactly one cycle between conversions.
- Results 0x40, 0x40, 0x40, 0x43 -> 0x40 without SAR_SEQ_ROUND_EN, 0x41 with it; four results of 0xFF with rounding -> 0xFF (saturation).
- Hold `valid`=0 with TIMEOUT_CYC=32 -> `go` falls after 32 cycles high, `timeout_err`=1, FSM back in IDLE; pulse `clr_err` -> flag cleared.
- `out_ready`=0 while 5 samples are produced with FIFO_DEPTH=4 -> 4 samples held in order, `overflow`=1 on the 5th push; same-cycle push and pop when full -> no overflow.
- Drop `enable` after 2 of 4 conversions -> partial average discarded, no push; re-enable -> next sample averages 4 fresh conversions.
- Assert `rst` mid-RUN -> `go`=0 asynchronously, FIFO empty, all flags 0.
